// File: rtl/lc3_mem_responder.sv
// Memory-side slave for the LC-3 memEN/memWE/memRDY handshake: word-addressed RAM
// with a fixed number of wait states; the device page at MMIO_BASE and above completes without storage.
module lc3_mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] MMIO_BASE   = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memory_addr,
    input  logic [15:0] memory_din,
    input  logic        memWE,
    input  logic        memEN,
    output logic [15:0] memory_dout,
    output logic        memRDY,
    output logic        busy,
    output logic        mmio_hit,
    output logic [1:0]  dbg_state_o
);

    // Handshake: memEN is held high by the CPU until it sees memRDY; memRDY is a
    // one-cycle strobe and memory_dout is valid in that cycle. Dropping memEN
    // while a transaction waits aborts it silently.
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] addr_q;
    logic [15:0] din_q;
    logic        we_q;
    logic [15:0] dout_q;
    logic        rdy_q;
    logic        busy_q;
    logic        mmio_q;

    logic [15:0] ram_q [2**ADDR_WIDTH];

    logic                  in_wait;
    logic                  start;
    logic                  complete;
    logic [15:0]           eff_addr;
    logic [15:0]           eff_din;
    logic                  eff_we;
    logic                  eff_mmio;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_idx;

    // With zero wait states the completion happens at the latching edge, so the
    // live bus values are used instead of the latched copies.
    always_comb begin
        in_wait  = (state_q == ST_WAIT);
        start    = !in_wait && memEN;
        eff_addr = in_wait ? addr_q : memory_addr;
        eff_din  = in_wait ? din_q  : memory_din;
        eff_we   = in_wait ? we_q   : memWE;
        complete = in_wait ? (memEN && cnt_q == 4'd1) : (memEN && WAIT_CYCLES == 0);
        eff_mmio = (eff_addr >= MMIO_BASE);
        ram_we   = complete && eff_we && !eff_mmio;
        ram_idx  = eff_addr[ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            din_q   <= 16'h0000;
            we_q    <= 1'b0;
            dout_q  <= 16'h0000;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            mmio_q  <= 1'b0;
        end else begin
            rdy_q  <= 1'b0;
            mmio_q <= 1'b0;
            if (start) begin
                addr_q <= memory_addr;
                din_q  <= memory_din;
                we_q   <= memWE;
                cnt_q  <= WAIT_LD;
            end
            if (complete) begin
                state_q <= ST_DONE;
                rdy_q   <= 1'b1;
                busy_q  <= 1'b0;
                mmio_q  <= eff_mmio;
                if (!eff_we) begin
                    dout_q <= eff_mmio ? 16'h0000 : ram_q[ram_idx];
                end
            end else if (start) begin
                state_q <= ST_WAIT;
                busy_q  <= 1'b1;
            end else if (in_wait) begin
                if (memEN) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

    // RAM contents survive reset; writes only occur on a completion edge.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= eff_din;
        end
    end

    assign memory_dout = dout_q;
    assign memRDY      = rdy_q;
    assign busy        = busy_q;
    assign mmio_hit    = mmio_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: randomized and directed transactions
// scored against an array-based memory model through an expected-response queue.
module tb_lc3_mem_responder;

    localparam int          AW   = 10;
    localparam int          W    = 2;
    localparam logic [15:0] MMIO = 16'hFE00;

    logic        clk;
    logic        rst;
    logic [15:0] memory_addr;
    logic [15:0] memory_din;
    logic        memWE;
    logic        memEN;
    logic [15:0] memory_dout;
    logic        memRDY;
    logic        busy;
    logic        mmio_hit;
    logic [1:0]  dbg_state;

    lc3_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W), .MMIO_BASE(MMIO)) dut (
        .clk(clk), .rst(rst), .memory_addr(memory_addr), .memory_din(memory_din),
        .memWE(memWE), .memEN(memEN), .memory_dout(memory_dout), .memRDY(memRDY),
        .busy(busy), .mmio_hit(mmio_hit), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];
    logic [15:0] model_mem [int];
    logic [15:0] last_dout = 16'h0000;
    logic [16:0] mon_e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word index is the address modulo the RAM depth; the device page never stores.
    task automatic txn(input logic [15:0] a, input logic we, input logic [15:0] d);
        int          n;
        int          idx;
        logic        mm;
        logic [15:0] ed;
        memory_addr = a;
        memory_din  = d;
        memWE       = we;
        memEN       = 1'b1;
        mm  = (a >= MMIO);
        idx = int'(a) % (1 << AW);
        if (!we) begin
            ed        = mm ? 16'h0000 : model_mem[idx];
            last_dout = ed;
        end else begin
            if (!mm) model_mem[idx] = d;
            ed = last_dout;
        end
        exp_q.push_back({mm, ed});
        @(posedge clk);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (memRDY) break;
            chk("busy_in_wait", int'(busy), 1);
        end
        chk("rdy_latency", n, W + 1);
        chk("busy_at_rdy", int'(busy), 0);
    endtask

    task automatic go_idle();
        memEN = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst && memRDY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got memRDY=1 expected none at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdy_dout", int'(memory_dout), int'(mon_e[15:0]));
                chk("rdy_mmio", int'(mmio_hit), int'(mon_e[16]));
            end
        end else if (rst) begin
            chk("mmio_idle", int'(mmio_hit), 0);
        end
    end

    initial begin
        logic [15:0] a;
        rst = 1'b0;
        memory_addr = 16'hFE00;
        memory_din  = 16'h0000;
        memWE       = 1'b0;
        memEN       = 1'b1;

        // Reset held with a request pending.
        repeat (3) begin
            @(negedge clk);
            chk("rst_rdy", int'(memRDY), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_dout", int'(memory_dout), 0);
        end
        rst = 1'b1;
        txn(16'hFE00, 1'b0, 16'h0000);
        go_idle();

        // Write then read.
        txn(16'h3000, 1'b1, 16'hBEEF); go_idle();
        txn(16'h3000, 1'b0, 16'h0000); go_idle();

        // Back-to-back reads with memEN held through memRDY.
        txn(16'h0010, 1'b1, 16'h1111); go_idle();
        txn(16'h0011, 1'b1, 16'h2222); go_idle();
        txn(16'h0010, 1'b0, 16'h0000);
        txn(16'h0011, 1'b0, 16'h0000);
        go_idle();

        // Device page and aliasing.
        txn(16'h0202, 1'b1, 16'h5A5A); go_idle();
        txn(16'hFE00, 1'b0, 16'h0000); go_idle();
        txn(16'hFE02, 1'b1, 16'h1234); go_idle();
        txn(16'h0202, 1'b0, 16'h0000); go_idle();
        txn(16'h0400, 1'b1, 16'hAAAA); go_idle();
        txn(16'h0000, 1'b0, 16'h0000); go_idle();

        // Abort one cycle into a write.
        txn(16'h0005, 1'b1, 16'h0505); go_idle();
        memory_addr = 16'h0005; memory_din = 16'h5555; memWE = 1'b1; memEN = 1'b1;
        @(posedge clk);
        #1 memEN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rdy", int'(memRDY), 0);
        repeat (W + 2) @(negedge clk);
        #1;
        txn(16'h0005, 1'b0, 16'h0000); go_idle();

        // Reset during the wait of a write.
        txn(16'h0006, 1'b1, 16'h0606); go_idle();
        memory_addr = 16'h0006; memory_din = 16'h6666; memWE = 1'b1; memEN = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        memEN = 1'b0;
        @(negedge clk);
        chk("midrst_rdy", int'(memRDY), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_dout", int'(memory_dout), 0);
        last_dout = 16'h0000;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (W + 3) @(negedge clk);
        #1;
        txn(16'h0006, 1'b0, 16'h0000); go_idle();

        // Randomized traffic over a small aliased window plus the device page.
        for (int i = 0; i < 32; i++) begin
            txn(16'(i), 1'b1, 16'($urandom_range(0, 16'hFFFF)));
            go_idle();
        end
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0)
                a = MMIO + 16'($urandom_range(0, 511));
            else
                a = 16'(($urandom_range(0, 62) << AW) | $urandom_range(0, 31));
            txn(a, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)));
            if ($urandom_range(0, 1) == 0) go_idle();
        end
        go_idle();

        repeat (W + 4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
Memory-side responder for the LC-3 CPU memory port: the slave end of the memEN/memWE/memRDY handshake the CPU initiates. It backs a word-addressed RAM with a fixed number of wait states and returns read data on memory_dout with a one-cycle memRDY strobe. Addresses in the device page (MMIO_BASE and above) are completed but not stored, so the MMIO decoder can sit alongside it. Used as the synthesizable memory in the CPU top level and as the reference slave in the testbench.

Parameters:
ADDR_WIDTH, 10, RAM depth = 2**ADDR_WIDTH words; memory_addr[ADDR_WIDTH-1:0] indexes the array, upper bits are ignored (wrap-around).
WAIT_CYCLES, 2, wait states per access (0..15); memRDY latency = WAIT_CYCLES+1 cycles.
MMIO_BASE, 16'hFE00, addresses >= MMIO_BASE bypass the RAM.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
memory_addr  in  16  word address from CPU
memory_din  in  16  write data from CPU
memWE  in  1  1 = write, 0 = read; valid while memEN is high
memEN  in  1  request; held high by the CPU until memRDY
memory_dout  out  16  read data, registered, valid in the memRDY cycle and held until the next completed read
memRDY  out  1  one-cycle completion strobe
busy  out  1  high while a transaction is latched and not yet completed
mmio_hit  out  1  pulses with memRDY when the completed address was >= MMIO_BASE

Behaviour:
- Reset (rst low, asynchronous): state IDLE, memRDY=0, busy=0, mmio_hit=0, memory_dout=16'h0000, wait counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE: at an edge with memEN=1, latch addr, din and WE; load counter=WAIT_CYCLES.
  - If WAIT_CYCLES=0, go directly to the completion action at that same edge (memRDY=1 in the next cycle).
  - Otherwise go to WAIT and set busy=1.
- WAIT: at each edge, decrement the counter if memEN=1. When the counter reaches 1, perform the completion action at that edge.
  - memEN=0 in WAIT: abort. Return to IDLE, busy=0, no write, no memRDY, memory_dout unchanged.
- Completion action (registered): memRDY=1 for exactly one cycle and busy=0.
  - Read, RAM page: memory_dout=RAM[addr].
  - Read, MMIO page: memory_dout=16'h0000 and mmio_hit=1.
  - Write, RAM page: RAM[addr]=din; memory_dout unchanged.
  - Write, MMIO page: write dropped, mmio_hit=1.
- DONE (the memRDY cycle): this state is equivalent to IDLE. memEN=1 here starts a new transaction; back-to-back accesses are allowed with no dead cycle.
- Latency: memEN first sampled high at edge N gives memRDY high in the cycle after edge N+WAIT_CYCLES.
- Address, data and WE changes after latching are ignored until the next transaction.
- Read-after-write to the same address returns the newly written value.
- Addresses that differ only above ADDR_WIDTH (below MMIO_BASE) alias the same word.
- Reset asserted mid-transaction: the transaction is discarded, no write occurs, and no memRDY follows reset release.

Test Plan:
- Reset: hold rst=0 for 3 cycles with memEN=1 -> memRDY=0, busy=0, memory_dout=0000 throughout; after release, the first memRDY appears exactly WAIT_CYCLES+1 cycles after memEN is sampled.
- Write then read (WAIT_CYCLES=2): write 0x3000<=16'hBEEF, then read 0x3000 -> memRDY high 3 cycles after each memEN sample, memory_dout=BEEF, mmio_hit=0.
- Back-to-back: hold memEN=1 through memRDY with reads of 0x0010 then 0x0011 (preloaded 1111/2222) -> memRDY pulses 3 cycles apart, dout 1111 then 2222, no idle gap.
- MMIO and aliasing: read 0xFE00 -> dout=0000 with mmio_hit=1; write 0xFE02<=1234 -> RAM unchanged; write 0x0400<=AAAA with ADDR_WIDTH=10, then read 0x0000 -> AAAA.
- Abort: drop memEN one cycle into a write of 0x0005<=5555 -> no memRDY, busy falls; a read of 0x0005 returns the old value.
- Reset mid-wait: assert rst during WAIT of a write -> no write, no memRDY after release, next access behaves normally.
